// File: rtl/output_port_allocator.sv
// Output port allocator: locks one upstream grant per packet and forwards its
// flits through a single registered output stage until the tail flit.
//
// Optional feature: define OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN to add a stall
// watchdog that releases the lock after TIMEOUT cycles without a transfer.
//
// Ports:
//   clk_i, rst_i  - clock (rising edge), synchronous active-high reset
//   req_i         - per-input request (same vector seen by the upstream arbiter)
//   grant_i       - one-hot grant from the upstream static priority arbiter
//   data_i        - per-input flit data, input k at [k*DATA_W +: DATA_W]
//   valid_i       - per-input flit valid
//   last_i        - per-input tail marker, qualified by valid_i
//   ready_o       - per-input flit accept (combinational from registered state)
//   data_o        - registered output flit
//   valid_o       - registered output valid
//   last_o        - registered output tail marker
//   ready_i       - downstream accept
//   lock_o        - currently held one-hot grant, zero when unlocked
//   timeout_o     - one-cycle pulse when the watchdog releases the lock
module output_port_allocator #(
    parameter int unsigned IN_N    = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [IN_N-1:0]        req_i,
    input  logic [IN_N-1:0]        grant_i,
    input  logic [IN_N*DATA_W-1:0] data_i,
    input  logic [IN_N-1:0]        valid_i,
    input  logic [IN_N-1:0]        last_i,
    output logic [IN_N-1:0]        ready_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   valid_o,
    output logic                   last_o,
    input  logic                   ready_i,
    output logic [IN_N-1:0]        lock_o,
    output logic                   timeout_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IN_N-1:0]     lock_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic                last_d;
    logic [IN_N-1:0]     take;
    logic                xfer;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;

    // req_i is only meaningful to the upstream arbiter; grant_i carries the decision
    logic unused_cfg;
    assign unused_cfg = ^{req_i, 32'(TIMEOUT)};

    // Accept only on the locked input, and only when the output stage can take a flit
    assign ready_o = lock_o & {IN_N{~valid_o | ready_i}};
    assign take    = valid_i & ready_o;
    assign xfer    = |take;

    // Lock is one-hot, so an OR-mux over accepted inputs selects the single source
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < int'(IN_N); k++) begin
            if (take[k]) begin
                sel_data = sel_data | data_i[k*DATA_W +: DATA_W];
                sel_last = sel_last | last_i[k];
            end
        end
    end

`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_d;
    logic             expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        lock_d  = lock_o;
        data_d  = data_o;
        last_d  = last_o;
        // Downstream drain clears the stage unless a new flit loads below
        valid_d = valid_o & ~ready_i;
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|grant_i) begin
                    state_d = LOCKED;
                    lock_d  = grant_i;
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            LOCKED: begin
                if (xfer) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    valid_d = 1'b1;
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (sel_last) begin
                        state_d = IDLE;
                        lock_d  = '0;
                    end
                end
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
                else if (expired) begin
                    // Stalled source: give the output back without touching the flit stage
                    state_d   = IDLE;
                    lock_d    = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                lock_d  = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lock_o  <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lock_o  <= lock_d;
            data_o  <= data_d;
            valid_o <= valid_d;
            last_o  <= last_d;
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_o <= timeout_d;
`endif
        end
    end

`ifndef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: a packet-level reference model
// predicts lock/ready/timeout per cycle and the ordered flit stream; a monitor
// compares the DUT against those predictions at the falling edge.
module tb_output_port_allocator;

    localparam int IN_N    = 5;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 4;
    localparam int BUS_W   = IN_N * DATA_W;

    logic               clk;
    logic               rst_i;
    logic [IN_N-1:0]    req_i;
    logic [IN_N-1:0]    grant_i;
    logic [BUS_W-1:0]   data_i;
    logic [IN_N-1:0]    valid_i;
    logic [IN_N-1:0]    last_i;
    logic [IN_N-1:0]    ready_o;
    logic [DATA_W-1:0]  data_o;
    logic               valid_o;
    logic               last_o;
    logic               ready_i;
    logic [IN_N-1:0]    lock_o;
    logic               timeout_o;

    output_port_allocator #(
        .IN_N   (IN_N),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .grant_i  (grant_i),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .last_o   (last_o),
        .ready_i  (ready_i),
        .lock_o   (lock_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IN_N-1:0] lock;
        logic [IN_N-1:0] rdy;
        logic            tmo;
        logic            vo;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } flit_t;

    ctrl_t ctrl_q[$];
    flit_t flit_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which input owns the output, whether a flit is held, stall count
    int owner = -1;
    bit mvo   = 1'b0;
    bit mtmo  = 1'b0;
    int stall = 0;

    function automatic logic [BUS_W-1:0] at(input int k, input logic [DATA_W-1:0] v);
        logic [BUS_W-1:0] b;
        b = '0;
        b[k*DATA_W +: DATA_W] = v;
        return b;
    endfunction

    // Drive one cycle of inputs, record the model's expectations, advance past the edge
    task automatic step(input logic r, input logic [IN_N-1:0] rq, input logic [IN_N-1:0] gt,
                        input logic [IN_N-1:0] vl, input logic [IN_N-1:0] ls,
                        input logic [BUS_W-1:0] dt, input logic rd);
        ctrl_t c;
        flit_t f;
        bit    xf;
        bit    vo_n;
        bit    tmo_n;
        rst_i   = r;
        req_i   = rq;
        grant_i = gt;
        valid_i = vl;
        last_i  = ls;
        data_i  = dt;
        ready_i = rd;

        c.lock = '0;
        if (owner >= 0) c.lock[owner] = 1'b1;
        c.rdy = (owner >= 0 && (!mvo || rd)) ? c.lock : '0;
        c.tmo = mtmo;
        c.vo  = mvo;
        ctrl_q.push_back(c);

        if (r) begin
            // A held flit that is not drained this cycle is lost to the reset
            if (mvo && !rd) void'(flit_q.pop_back());
            owner = -1;
            mvo   = 1'b0;
            mtmo  = 1'b0;
            stall = 0;
        end else begin
            xf = 1'b0;
            if (c.rdy != '0) xf = vl[owner];
            vo_n  = mvo && !rd;
            tmo_n = 1'b0;
            if (owner < 0) begin
                if (gt != '0) begin
                    for (int k = 0; k < IN_N; k++) if (gt[k]) owner = k;
                    stall = 0;
                end
            end else if (xf) begin
                f.d = dt[owner*DATA_W +: DATA_W];
                f.l = ls[owner];
                flit_q.push_back(f);
                vo_n  = 1'b1;
                stall = 0;
                if (ls[owner]) owner = -1;
            end else begin
`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
                stall++;
                if (stall == TIMEOUT) begin
                    owner = -1;
                    tmo_n = 1'b1;
                    stall = 0;
                end
`endif
            end
            mvo  = vo_n;
            mtmo = tmo_n;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare control outputs every cycle, and each consumed flit in order
    ctrl_t e;
    flit_t fx;
    always @(negedge clk) begin
        if (ctrl_q.size() != 0) begin
            e = ctrl_q.pop_front();
            n_tests++;
            if (lock_o !== e.lock || ready_o !== e.rdy || timeout_o !== e.tmo || valid_o !== e.vo) begin
                n_fail++;
                $display("FAIL ctrl t=%0t lock=%b exp %b ready=%b exp %b timeout=%b exp %b valid=%b exp %b",
                         $time, lock_o, e.lock, ready_o, e.rdy, timeout_o, e.tmo, valid_o, e.vo);
            end
            if (e.vo && ready_i) begin
                n_tests++;
                if (flit_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL flit t=%0t consumed data=%h last=%b but none expected",
                             $time, data_o, last_o);
                end else begin
                    fx = flit_q.pop_front();
                    if (data_o !== fx.d || last_o !== fx.l) begin
                        n_fail++;
                        $display("FAIL flit t=%0t data=%h exp %h last=%b exp %b",
                                 $time, data_o, fx.d, last_o, fx.l);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_N-1:0]  rq;
        logic [IN_N-1:0]  gt;
        logic [IN_N-1:0]  vl;
        logic [IN_N-1:0]  ls;
        logic [BUS_W-1:0] dt;
        logic             r;
        logic             rd;

        rst_i = 1'b1; req_i = '0; grant_i = '0; data_i = '0;
        valid_i = '0; last_i = '0; ready_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Zero grant with a pending request stays idle
        repeat (4) step(0, 5'b00001, 5'b00000, 0, 0, 0, 1);

        // Single packet on input 2; input 4 tries to cut in while locked
        step(0, 5'b00100, 5'b00100, 0, 0, 0, 1);
        step(0, 5'b10100, 5'b10000, 5'b10100, 0, at(2, 8'hA1) | at(4, 8'hEE), 1);
        step(0, 5'b10100, 5'b10000, 5'b10100, 0, at(2, 8'hA2) | at(4, 8'hEE), 1);
        step(0, 5'b10100, 5'b10000, 5'b10100, 5'b00100, at(2, 8'hA3) | at(4, 8'hEE), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Backpressure then release with simultaneous drain and load
        step(0, 5'b00100, 5'b00100, 0, 0, 0, 1);
        step(0, 5'b00100, 0, 5'b00100, 0, at(2, 8'hB1), 1);
        repeat (3) step(0, 5'b00100, 0, 5'b00100, 0, at(2, 8'hB2), 0);
        step(0, 5'b00100, 0, 5'b00100, 0, at(2, 8'hB2), 1);
        step(0, 5'b00100, 0, 5'b00100, 5'b00100, at(2, 8'hB3), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Stalled lock on input 1: watchdog release when enabled, held otherwise
        step(0, 5'b00010, 5'b00010, 0, 0, 0, 1);
        repeat (8) step(0, 5'b00010, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset mid-packet with a held output flit
        step(0, 5'b01000, 5'b01000, 0, 0, 0, 1);
        step(0, 5'b01000, 0, 5'b01000, 0, at(3, 8'hC1), 1);
        step(0, 5'b01000, 0, 5'b01000, 0, at(3, 8'hC2), 0);
        step(1, 5'b01000, 0, 5'b01000, 0, at(3, 8'hC2), 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic with priority-arbitrated grants
        for (int i = 0; i < 2000; i++) begin
            rq = IN_N'($urandom);
            gt = rq & (~rq + 1'b1);
            if ($urandom_range(0, 4) == 0) gt = '0;
            vl = IN_N'($urandom);
            ls = IN_N'($urandom) & IN_N'($urandom);
            dt = BUS_W'({$urandom, $urandom});
            r  = ($urandom_range(0, 99) == 0);
            rd = ($urandom_range(0, 3) != 0);
            step(r, rq, gt, vl, ls, dt, rd);
        end

        // Drain the output stage and confirm every predicted flit was seen
        repeat (4) step(0, 0, 0, 0, 0, 0, 1);
        n_tests++;
        if (flit_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp 0", flit_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
